capp_tag_unit: RTL and testbench

- Parametrised tag register bank for the CAPP word array; successor to the fixed 100-word tag flip-flop chain.
- Latches per-word match results under a command opcode and combines them with current tags (load/AND/OR).
- Provides set-all, clear-all and select-first resolution, plus a multi-cycle iterator that hands tagged word indices to the controller one per handshake.
- Sits between the match-line comparators and the sequencer/response resolver.

---
 rtl/capp_tag_unit.sv | 129 ++++++++++++
 tb/tb_capp_tag_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capp_tag_unit.sv
// capp_tag_unit: parametrised CAPP tag register bank with load/combine ops, select-first and a tag iterator.
// Optional build macro TAG_COUNT_EN adds a registered popcount output tag_count.
module capp_tag_unit #(
    parameter int WORDS = 100,
    parameter int IDXW  = $clog2(WORDS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WORDS-1:0] match_lines,
    output logic [WORDS-1:0] tags,
    output logic             some_none,
    output logic [IDXW-1:0]  first_idx,
`ifdef TAG_COUNT_EN
    output logic [IDXW:0]    tag_count,
`endif
    output logic             iter_valid,
    output logic [IDXW-1:0]  iter_idx,
    input  logic             iter_ready,
    output logic             iter_done
);

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_LOAD         = 3'd1,
        OP_AND          = 3'd2,
        OP_OR           = 3'd3,
        OP_SET_ALL      = 3'd4,
        OP_CLEAR        = 3'd5,
        OP_SELECT_FIRST = 3'd6,
        OP_STEP         = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_e;

    localparam logic [WORDS-1:0] ONE = WORDS'(1);

    state_e           state;
    logic [WORDS-1:0] lowest;
    logic [WORDS-1:0] rest;
    logic             accept;

    // Two's-complement trick isolates the lowest set tag without a priority chain.
    assign lowest    = tags & (~tags + ONE);
    assign rest      = tags & ~lowest;
    assign some_none = |tags;
    assign iter_idx  = first_idx;
    assign accept    = cmd_valid && cmd_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        first_idx = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (tags[i]) first_idx = IDXW'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            tags       <= '0;
            cmd_ready  <= 1'b1;
            iter_valid <= 1'b0;
            iter_done  <= 1'b0;
        end else begin
            iter_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_e'(cmd_op))
                            OP_LOAD:         tags <= match_lines;
                            OP_AND:          tags <= tags & match_lines;
                            OP_OR:           tags <= tags | match_lines;
                            OP_SET_ALL:      tags <= '1;
                            OP_CLEAR:        tags <= '0;
                            OP_SELECT_FIRST: tags <= lowest;
                            OP_STEP: begin
                                if (some_none) begin
                                    state      <= ST_ITER;
                                    cmd_ready  <= 1'b0;
                                    iter_valid <= 1'b1;
                                end else begin
                                    iter_done  <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ITER: begin
                    // The presented index is always the lowest set tag, so clearing it advances the walk.
                    if (iter_ready) begin
                        tags <= rest;
                        if (rest == '0) begin
                            state      <= ST_IDLE;
                            cmd_ready  <= 1'b1;
                            iter_valid <= 1'b0;
                            iter_done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TAG_COUNT_EN
    logic [IDXW:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WORDS; i++) begin
            pop = pop + (IDXW+1)'(tags[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tag_count <= '0;
        else        tag_count <= pop;
    end
`endif

endmodule

// File: tb/tb_capp_tag_unit.sv
// Self-checking bench for capp_tag_unit (WORDS=100): scoreboard of expected tags and iterator indices.
module tb_capp_tag_unit;

    localparam int WORDS = 100;
    localparam int IDXW  = $clog2(WORDS);

    localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_SET_ALL = 3'd4, OP_CLEAR = 3'd5, OP_SELECT_FIRST = 3'd6, OP_STEP = 3'd7;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WORDS-1:0] match_lines;
    logic [WORDS-1:0] tags;
    logic             some_none;
    logic [IDXW-1:0]  first_idx;
    logic             iter_valid;
    logic [IDXW-1:0]  iter_idx;
    logic             iter_ready;
    logic             iter_done;
`ifdef TAG_COUNT_EN
    logic [IDXW:0]    tag_count;
`endif

    capp_tag_unit #(.WORDS(WORDS)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .match_lines (match_lines),
        .tags        (tags),
        .some_none   (some_none),
        .first_idx   (first_idx),
`ifdef TAG_COUNT_EN
        .tag_count   (tag_count),
`endif
        .iter_valid  (iter_valid),
        .iter_idx    (iter_idx),
        .iter_ready  (iter_ready),
        .iter_done   (iter_done)
    );

    always #5 CLK = ~CLK;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WORDS-1:0] model_tags;
    logic [WORDS-1:0] exp_q[$];
    int               idx_q[$];

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [WORDS-1:0] model_op(input logic [2:0] op, input logic [WORDS-1:0] t,
                                                  input logic [WORDS-1:0] m);
        logic [WORDS-1:0] r;
        r = t;
        case (op)
            OP_LOAD:    r = m;
            OP_AND:     r = t & m;
            OP_OR:      r = t | m;
            OP_SET_ALL: r = '1;
            OP_CLEAR:   r = '0;
            OP_SELECT_FIRST: begin
                r = '0;
                for (int i = 0; i < WORDS; i++) begin
                    if (t[i]) begin
                        r[i] = 1'b1;
                        break;
                    end
                end
            end
            default: r = t;
        endcase
        return r;
    endfunction

    function automatic int low_idx(input logic [WORDS-1:0] t);
        for (int i = 0; i < WORDS; i++) begin
            if (t[i]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [WORDS-1:0] m);
        cmd_op      = op;
        match_lines = m;
        cmd_valid   = 1'b1;
        exp_q.push_back(model_op(op, model_tags, m));
        tick();
        cmd_valid  = 1'b0;
        model_tags = exp_q.pop_front();
        check("tags", tags, model_tags);
        check("some_none", some_none, |model_tags);
        check("first_idx", first_idx, low_idx(model_tags));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WORDS-1:0] m;
        int               stall;

        RST_N       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = OP_NOP;
        match_lines = '0;
        iter_ready  = 1'b0;
        model_tags  = '0;

        #12;
        check("rst_tags", tags, 0);
        check("rst_some_none", some_none, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_iter_valid", iter_valid, 0);
        check("rst_iter_done", iter_done, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Load / combine / resolve sequence
        do_cmd(OP_LOAD, WORDS'(64'h0A_0000_0005));
        m = '0; m[2] = 1'b1; m[17] = 1'b1;
        do_cmd(OP_AND, m);
        check("and_first_idx_2", first_idx, 2);
        m = '0; m[99] = 1'b1;
        do_cmd(OP_OR, m);
        do_cmd(OP_NOP, '1);
        do_cmd(OP_SELECT_FIRST, '0);
        do_cmd(OP_CLEAR, '0);
        do_cmd(OP_SELECT_FIRST, '0);
        do_cmd(OP_SET_ALL, '0);
`ifdef TAG_COUNT_EN
        tick();
        check("tag_count_all", tag_count, 100);
`endif
        m = '0; m[99] = 1'b1; m[98] = 1'b1;
        do_cmd(OP_AND, m);
        check("top_first_idx", first_idx, 98);

        // Iteration over {3,40,99} with an initial 3-cycle stall
        m = '0; m[3] = 1'b1; m[40] = 1'b1; m[99] = 1'b1;
        do_cmd(OP_LOAD, m);
        idx_q.push_back(3);
        idx_q.push_back(40);
        idx_q.push_back(99);
        cmd_op    = OP_STEP;
        cmd_valid = 1'b1;
        tick();
        // Sender keeps a SET_ALL pending; it must be ignored while iterating.
        cmd_op = OP_SET_ALL;
        stall  = 0;
        for (int cyc = 0; cyc < 20 && idx_q.size() > 0; cyc++) begin
            check("iter_valid", iter_valid, 1);
            check("iter_cmd_ready", cmd_ready, 0);
            check("iter_no_done", iter_done, 0);
            check("iter_idx", iter_idx, idx_q[0]);
            if (stall < 3) begin
                iter_ready = 1'b0;
                stall++;
            end else begin
                iter_ready = 1'b1;
            end
            tick();
            if (iter_ready) void'(idx_q.pop_front());
            if (idx_q.size() == 0) cmd_valid = 1'b0;
        end
        check("iter_remaining", idx_q.size(), 0);
        cmd_valid  = 1'b0;
        iter_ready = 1'b0;
        model_tags = '0;
        check("iter_done_pulse", iter_done, 1);
        check("iter_end_valid", iter_valid, 0);
        check("iter_end_tags", tags, 0);
        check("iter_end_cmd_ready", cmd_ready, 1);
        tick();
        check("iter_done_once", iter_done, 0);

        // STEP on empty tags
        cmd_op    = OP_STEP;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("empty_step_valid", iter_valid, 0);
        check("empty_step_done", iter_done, 1);
        check("empty_step_ready", cmd_ready, 1);
        tick();
        check("empty_step_done_once", iter_done, 0);
        check("empty_step_valid2", iter_valid, 0);

        // Async reset in the middle of an iteration
        m = '0; m[5] = 1'b1; m[6] = 1'b1; m[7] = 1'b1;
        do_cmd(OP_LOAD, m);
        cmd_op    = OP_STEP;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("mid_valid", iter_valid, 1);
        check("mid_idx_a", iter_idx, 5);
        iter_ready = 1'b1;
        tick();
        iter_ready = 1'b0;
        check("mid_idx_b", iter_idx, 6);
        #2;
        RST_N = 1'b0;
        #1;
        model_tags = '0;
        check("mid_rst_tags", tags, 0);
        check("mid_rst_valid", iter_valid, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_done", iter_done, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_no_done", iter_done, 0);
            check("post_rst_no_valid", iter_valid, 0);
        end
        do_cmd(OP_NOP, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
